// File: rtl/next_pc_stage_pkg.sv
// Shared types and helpers for the next-PC stage.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package next_pc_stage_pkg;

  localparam int unsigned DEF_FETCH_WIDTH   = 2;
  localparam int unsigned DEF_PC_WIDTH      = 32;
  localparam int unsigned DEF_INSN_BYTES    = 4;
  localparam int unsigned DEF_SID_WIDTH     = 16;
  localparam int unsigned FETCH_GROUP_BYTES = DEF_FETCH_WIDTH * DEF_INSN_BYTES;

  typedef logic [DEF_PC_WIDTH-1:0]  pc_t;
  typedef logic [DEF_SID_WIDTH-1:0] sid_t;

  // Ordered so that a numerically larger value always wins.
  typedef enum logic [1:0] {
    PRIO_NONE    = 2'd0,
    PRIO_PRED    = 2'd1,
    PRIO_MISPRED = 2'd2,
    PRIO_RECOVER = 2'd3
  } redirect_prio_e;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_WARMUP,
    ST_RUN,
    ST_HOLD
  } state_e;

  // PC of one lane inside an aligned fetch group.
  function automatic pc_t lane_pc(pc_t base, int unsigned lane, int unsigned insn_bytes);
    return base + pc_t'(lane * insn_bytes);
  endfunction

endpackage

// File: rtl/next_pc_stage_if.sv
// Control/redirect inputs and fetch-group outputs of the next-PC stage.
// Latency: n/a (wiring only).
// Backpressure: stall is the only flow control; outputs are held while it is high.
interface next_pc_stage_if #(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned SID_WIDTH   = 16
);
  logic                                  stall;
  logic                                  clear;
  logic                                  recover_valid;
  logic [PC_WIDTH-1:0]                   recover_pc;
  logic                                  mispred_valid;
  logic [PC_WIDTH-1:0]                   mispred_pc;
  logic                                  pred_valid;
  logic [PC_WIDTH-1:0]                   pred_pc;
  logic [PC_WIDTH-1:0]                   fetch_pc;
  logic [FETCH_WIDTH-1:0]                out_valid;
  logic [FETCH_WIDTH-1:0][PC_WIDTH-1:0]  out_pc;
  logic [FETCH_WIDTH-1:0][SID_WIDTH-1:0] out_sid;

  // Controller / back-end side.
  modport master (
    output stall, clear, recover_valid, recover_pc, mispred_valid, mispred_pc,
           pred_valid, pred_pc,
    input  fetch_pc, out_valid, out_pc, out_sid
  );

  // The next-PC stage itself.
  modport slave (
    input  stall, clear, recover_valid, recover_pc, mispred_valid, mispred_pc,
           pred_valid, pred_pc,
    output fetch_pc, out_valid, out_pc, out_sid
  );
endinterface

// File: rtl/next_pc_redirect_latch.sv
// Remembers the highest-priority redirect seen while the stage is stalled.
// Latency: captured redirect is visible on pending/pending_pc the next cycle.
// Backpressure: captures only while stalled; drained on the first unstalled cycle.
module next_pc_redirect_latch
  import next_pc_stage_pkg::*;
#(
  parameter int unsigned PC_WIDTH = DEF_PC_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                capture,
  input  logic                drain,
  input  redirect_prio_e      in_prio,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                pending,
  output logic [PC_WIDTH-1:0] pending_pc
);

  redirect_prio_e      prio_q;
  logic [PC_WIDTH-1:0] pending_pc_q;

  // Equal-or-higher priority overwrites; a weaker redirect cannot displace a stronger one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q       <= PRIO_NONE;
      pending_pc_q <= '0;
    end else if (capture && (in_prio != PRIO_NONE) && (in_prio >= prio_q)) begin
      prio_q       <= in_prio;
      pending_pc_q <= in_pc;
    end else if (drain) begin
      prio_q       <= PRIO_NONE;
    end
  end

  assign pending    = (prio_q != PRIO_NONE);
  assign pending_pc = pending_pc_q;

endmodule

// File: rtl/next_pc_stage.sv
// Owns the fetch PC: picks the next group address and emits per-lane valid/PC/SID.
// Latency: a redirect at cycle t shows on fetch_pc at t+1 (or the cycle after stall drops).
// Backpressure: stall holds pc_q and suppresses lanes; redirects seen while stalled are kept pending.
module next_pc_stage
  import next_pc_stage_pkg::*;
#(
  parameter int unsigned         FETCH_WIDTH     = DEF_FETCH_WIDTH,
  parameter int unsigned         PC_WIDTH        = DEF_PC_WIDTH,
  parameter int unsigned         INSN_BYTE_WIDTH = DEF_INSN_BYTES,
  parameter logic [PC_WIDTH-1:0] RESET_PC        = 32'h0000_1000,
  parameter int unsigned         SID_WIDTH       = DEF_SID_WIDTH
) (
  input logic              clk,
  input logic              rst,
  next_pc_stage_if.slave   bus
);

  localparam int unsigned GROUP_BYTES = FETCH_WIDTH * INSN_BYTE_WIDTH;
  localparam int unsigned GROUP_LSB   = $clog2(GROUP_BYTES);
  localparam int unsigned INSN_LSB    = $clog2(INSN_BYTE_WIDTH);
  localparam int unsigned LANE_W      = GROUP_LSB - INSN_LSB;

  state_e                                state_q, state_d;
  logic [PC_WIDTH-1:0]                   pc_q, pc_d, base, seq_pc, in_pc, pending_pc;
  logic [LANE_W-1:0]                     lane_off;
  logic                                  running, redirect_now, advance, pending;
  redirect_prio_e                        in_prio;
  logic [FETCH_WIDTH-1:0]                lane_vld;
  logic [FETCH_WIDTH-1:0][SID_WIDTH-1:0] lane_sid;
  logic [SID_WIDTH-1:0]                  sid_q, sid_inc;

  assign base         = {pc_q[PC_WIDTH-1:GROUP_LSB], {GROUP_LSB{1'b0}}};
  assign seq_pc       = base + PC_WIDTH'(GROUP_BYTES);
  assign lane_off     = pc_q[GROUP_LSB-1:INSN_LSB];
  assign running      = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign redirect_now = bus.recover_valid | bus.mispred_valid;
  // WARMUP only lets a recovery through; everything else waits for RUN.
  assign advance      = !bus.stall &&
                        (running || ((state_q == ST_WARMUP) && bus.recover_valid));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RESET;
    else     state_q <= state_d;
  end

  // Next state: one warmup cycle after reset, then RUN/HOLD tracks stall.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:                   state_d = ST_WARMUP;
      ST_WARMUP, ST_RUN, ST_HOLD: state_d = bus.stall ? ST_HOLD : ST_RUN;
      default:                    state_d = ST_RESET;
    endcase
  end

  // Strongest redirect presented this cycle, for the pending latch.
  always_comb begin
    in_prio = PRIO_NONE;
    in_pc   = bus.pred_pc;
    if (bus.recover_valid) begin
      in_prio = PRIO_RECOVER;
      in_pc   = bus.recover_pc;
    end else if (bus.mispred_valid) begin
      in_prio = PRIO_MISPRED;
      in_pc   = bus.mispred_pc;
    end else if (bus.pred_valid) begin
      in_prio = PRIO_PRED;
      in_pc   = bus.pred_pc;
    end
  end

  next_pc_redirect_latch #(.PC_WIDTH(PC_WIDTH)) u_latch (
    .clk        (clk),
    .rst        (rst),
    .capture    (bus.stall && (state_q != ST_RESET)),
    .drain      (!bus.stall && (state_q != ST_RESET)),
    .in_prio    (in_prio),
    .in_pc      (in_pc),
    .pending    (pending),
    .pending_pc (pending_pc)
  );

  // Next-PC select: live back-end redirects beat a remembered one, which beats prediction.
  always_comb begin
    pc_d = seq_pc;
    if      (bus.recover_valid) pc_d = bus.recover_pc;
    else if (bus.mispred_valid) pc_d = bus.mispred_pc;
    else if (pending)           pc_d = pending_pc;
    else if (bus.pred_valid)    pc_d = bus.pred_pc;
  end

  // Group PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          pc_q <= RESET_PC;
    else if (advance) pc_q <= pc_d;
  end

  // Lane valids and serial IDs; invalid lanes do not consume an ID.
  always_comb begin
    lane_vld = '0;
    lane_sid = '0;
    sid_inc  = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      lane_vld[i] = (LANE_W'(i) >= lane_off) && !bus.stall && !bus.clear &&
                    !redirect_now && running;
      lane_sid[i] = sid_q + sid_inc;
      sid_inc     = sid_inc + SID_WIDTH'(lane_vld[i]);
    end
  end

  // Serial-ID counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sid_q <= '0;
    else     sid_q <= sid_q + sid_inc;
  end

  for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_lane
    assign bus.out_pc[i] = lane_pc(base, i, INSN_BYTE_WIDTH);
  end

  assign bus.fetch_pc  = pc_q;
  assign bus.out_valid = lane_vld;
  assign bus.out_sid   = lane_sid;

endmodule
